// File: rtl/bgr_startup_ctrl_if.sv
// Signal bundle between the bandgap startup controller (slave) and the chip-level
// supervisor that requests startup and consumes the ready/fault status (master).
interface bgr_startup_ctrl_if;
  logic       en;
  logic       vbg_ok;
  logic       porst;
  logic       bgr_ready;
  logic       bgr_fault;
  logic [1:0] retry_cnt;

  modport master (
    output en, vbg_ok,
    input  porst, bgr_ready, bgr_fault, retry_cnt
  );

  modport slave (
    input  en, vbg_ok,
    output porst, bgr_ready, bgr_fault, retry_cnt
  );
endinterface

// File: rtl/bgr_startup_ctrl.sv
// Bandgap startup/supervision controller: kicks porst, settles, qualifies vbg_ok, reports ready/fault.
// Define BGR_STARTUP_WATCHDOG_EN to re-kick the bandgap on a sustained vbg_ok dropout in READY.
module bgr_startup_ctrl #(
  parameter int KICK_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 256,
  parameter int FILT_CYCLES   = 8,
  parameter int CHECK_CYCLES  = 64,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  bgr_startup_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KICK   = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    READY  = 3'd4,
    FAULT  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] KICK_LAST   = CNT_W'(KICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILT_LAST   = CNT_W'(FILT_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_run_s;
  logic [CNT_W-1:0] filt_r, filt_run_s;
  logic [1:0]       retry_r, retry_nxt_s;
  logic             sync1_r, sync2_r, ok_s;
  logic             porst_r, ready_r, fault_r;
  logic             stay_s;

  assign ok_s = sync2_r;

  // vbg_ok comes straight from an analog comparator: two-flop synchronizer before any use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= bus.vbg_ok;
      sync2_r <= sync1_r;
    end
  end

  // Next-state logic; cycle and filter counters restart from zero on every state entry
  always_comb begin
    state_nxt_s = state_r;
    retry_nxt_s = retry_r;
    cnt_run_s   = CNT_ZERO;
    filt_run_s  = CNT_ZERO;
    if (!bus.en) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = KICK;
          retry_nxt_s = 2'd0;
        end
        KICK: begin
          cnt_run_s = cnt_r + CNT_ONE;
          if (cnt_r == KICK_LAST) state_nxt_s = SETTLE;
          else                    state_nxt_s = KICK;
        end
        SETTLE: begin
          cnt_run_s = cnt_r + CNT_ONE;
          if (cnt_r == SETTLE_LAST) state_nxt_s = CHECK;
          else                      state_nxt_s = SETTLE;
        end
        CHECK: begin
          cnt_run_s  = cnt_r + CNT_ONE;
          filt_run_s = ok_s ? (filt_r + CNT_ONE) : CNT_ZERO;
          // qualification wins over a timeout landing on the same cycle
          if (ok_s && (filt_r == FILT_LAST)) begin
            state_nxt_s = READY;
          end else if (cnt_r == CHECK_LAST) begin
            if (retry_r < RETRY_MAX) begin
              retry_nxt_s = retry_r + 2'd1;
              state_nxt_s = KICK;
            end else begin
              state_nxt_s = FAULT;
            end
          end else begin
            state_nxt_s = CHECK;
          end
        end
        READY: begin
`ifdef BGR_STARTUP_WATCHDOG_EN
          filt_run_s = ok_s ? CNT_ZERO : (filt_r + CNT_ONE);
          if (!ok_s && (filt_r == FILT_LAST)) begin
            state_nxt_s = KICK;
            retry_nxt_s = 2'd0;
          end else begin
            state_nxt_s = READY;
          end
`else
          state_nxt_s = READY;
`endif
        end
        FAULT:   state_nxt_s = FAULT;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  assign stay_s = (state_nxt_s == state_r);

  // State, counters and state-decoded outputs; porst/ready/fault track the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      filt_r  <= CNT_ZERO;
      retry_r <= 2'd0;
      porst_r <= 1'b0;
      ready_r <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= stay_s ? cnt_run_s : CNT_ZERO;
      filt_r  <= stay_s ? filt_run_s : CNT_ZERO;
      retry_r <= retry_nxt_s;
      porst_r <= (state_nxt_s == KICK);
      ready_r <= (state_nxt_s == READY);
      fault_r <= (state_nxt_s == FAULT);
    end
  end

  assign bus.porst     = porst_r;
  assign bus.bgr_ready = ready_r;
  assign bus.bgr_fault = fault_r;
  assign bus.retry_cnt = retry_r;

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// Bench for bgr_startup_ctrl: directed and randomized vbg_ok traces compared every cycle
// against a timeline model that lays out kick/settle/check windows by arithmetic.
module tb_bgr_startup_ctrl;
  localparam int KICK   = 16;
  localparam int SETTLE = 256;
  localparam int FILT   = 8;
  localparam int CHECK  = 64;
  localparam int MAXR   = 3;
  localparam int MAXC   = 1600;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   fail_cnt = 0;

  // vin[r]: vbg_ok driven just after edge r; ex_*[r]: outputs expected just after edge r
  bit vin      [MAXC];
  bit ex_porst [MAXC];
  bit ex_ready [MAXC];
  bit ex_fault [MAXC];
  int ex_retry [MAXC];

  bgr_startup_ctrl_if bus ();

  bgr_startup_ctrl #(
    .KICK_CYCLES(KICK), .SETTLE_CYCLES(SETTLE), .FILT_CYCLES(FILT),
    .CHECK_CYCLES(CHECK), .MAX_RETRIES(MAXR), .CNT_W(12)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d at time %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit ok_at(input int i);
    return (i >= 0) ? vin[i] : 1'b0;
  endfunction

  task automatic fill(input int lo, input int hi, input bit v);
    for (int r = lo; r < hi && r < MAXC; r++) vin[r] = v;
  endtask

  task automatic gen_random(input int len);
    int r;
    r = 0;
    while (r < len) begin
      int seg;
      bit lvl;
      seg = $urandom_range(14, 1);
      lvl = ($urandom_range(9, 0) < 6);
      for (int k = 0; k < seg && r < len; k++) begin
        vin[r] = lvl;
        r++;
      end
    end
  endtask

  // Timeline model: startup requested so that the first kick starts at edge s+1
  task automatic predict(input int s, input int len);
    int t, retry, c, run, hit, stop;
    for (int r = 0; r < MAXC; r++) begin
      ex_porst[r] = 1'b0; ex_ready[r] = 1'b0; ex_fault[r] = 1'b0; ex_retry[r] = -1;
    end
    t = s + 1;
    retry = 0;
    while (t < len) begin
      c = t + KICK + SETTLE;
      for (int r = t; r < c && r < len; r++) begin
        ex_porst[r] = (r < t + KICK);
        ex_retry[r] = retry;
      end
      // the sample seen at edge e is the vbg_ok level driven three edges earlier
      run = 0;
      hit = -1;
      for (int e = c + 1; e <= c + CHECK; e++) begin
        run = ok_at(e - 3) ? run + 1 : 0;
        if (hit < 0 && run == FILT) hit = e;
      end
      stop = (hit >= 0) ? hit : c + CHECK;
      for (int r = c; r < stop && r < len; r++) ex_retry[r] = retry;
      if (hit >= 0) begin
        t = len;
        run = 0;
        for (int r = hit; r < len && t == len; r++) begin
          ex_ready[r] = 1'b1;
          ex_retry[r] = retry;
`ifdef BGR_STARTUP_WATCHDOG_EN
          if (r > hit) begin
            run = ok_at(r - 3) ? 0 : run + 1;
            if (run == FILT) begin
              ex_ready[r] = 1'b0;
              retry = 0;
              t = r;
            end
          end
`endif
        end
      end else if (retry < MAXR) begin
        retry++;
        t = c + CHECK;
      end else begin
        for (int r = c + CHECK; r < len; r++) begin
          ex_fault[r] = 1'b1;
          ex_retry[r] = retry;
        end
        t = len;
      end
    end
  endtask

  // en rises after edge e_start; if rel >= 0 rst_n (held low on entry) is released after edge rel
  task automatic run_scn(input int e_start, input int rel, input int len);
    predict((rel > e_start) ? rel : e_start, len);
    for (int r = 0; r < len; r++) begin
      @(posedge clk);
      #1;
      if (r == rel) rst_n = 1'b1;
      bus.en     = (r >= e_start);
      bus.vbg_ok = vin[r];
      @(negedge clk);
      chk("porst", bus.porst, ex_porst[r]);
      chk("bgr_ready", bus.bgr_ready, ex_ready[r]);
      chk("bgr_fault", bus.bgr_fault, ex_fault[r]);
      if (ex_retry[r] >= 0) chk("retry_cnt", bus.retry_cnt, ex_retry[r]);
    end
  endtask

  task automatic drop_en();
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("off_porst", bus.porst, 0);
    chk("off_ready", bus.bgr_ready, 0);
    chk("off_fault", bus.bgr_fault, 0);
  endtask

  initial begin
    bus.en     = 1'b0;
    bus.vbg_ok = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_porst", bus.porst, 0);
    chk("rst_ready", bus.bgr_ready, 0);
    chk("rst_fault", bus.bgr_fault, 0);
    chk("rst_retry", bus.retry_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_porst", bus.porst, 0);

    // vbg_ok tied high, en rises after edge 10: kick 11..26, ready at 291
    fill(0, MAXC, 1'b1);
    run_scn(10, -1, 300);
    chk("tied1_retry", bus.retry_cnt, 0);
    drop_en();

    // vbg_ok tied low: four kicks then sticky fault, cleared by dropping en
    fill(0, MAXC, 1'b0);
    run_scn(3, -1, 1360);
    chk("fault_set", bus.bgr_fault, 1);
    chk("fault_retry", bus.retry_cnt, 3);
    chk("fault_ready", bus.bgr_ready, 0);
    drop_en();

    // vbg_ok toggling every 4 cycles through the first check window, then held high
    for (int r = 0; r < MAXC; r++)
      vin[r] = (r < 6 + KICK + SETTLE + CHECK) ? bit'((r / 4) % 2) : 1'b1;
    run_scn(5, -1, 650);
    chk("toggle_retry", bus.retry_cnt, 1);
    chk("toggle_ready", bus.bgr_ready, 1);
    drop_en();

    // reset pulse in the middle of a kick: porst falls without waiting for a clock
    fill(0, MAXC, 1'b1);
    @(posedge clk);
    #1;
    bus.en = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("midkick_porst", bus.porst, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_porst", bus.porst, 0);
    chk("async_retry", bus.retry_cnt, 0);
    run_scn(0, 3, 300);
    drop_en();

    // en falling mid-kick drops porst at the next edge
    @(posedge clk);
    #1;
    bus.en = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("enkick_porst", bus.porst, 1);
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    @(negedge clk);
    chk("enkick_hold", bus.porst, 1);
    @(posedge clk);
    @(negedge clk);
    chk("enkick_drop", bus.porst, 0);

    // dropout in READY: 7 low cycles (ignored), recovery, then 10 low cycles
    fill(0, MAXC, 1'b1);
    fill(300, 307, 1'b0);
    fill(313, 323, 1'b0);
    run_scn(5, -1, 360);
`ifdef BGR_STARTUP_WATCHDOG_EN
    chk("wd_ready_dropped", bus.bgr_ready, 0);
    chk("wd_retry_cleared", bus.retry_cnt, 0);
`else
    chk("nowd_ready_held", bus.bgr_ready, 1);
`endif
    drop_en();

    // randomized vbg_ok traces
    for (int k = 0; k < 3; k++) begin
      int e0;
      int len;
      e0  = $urandom_range(12, 2);
      len = e0 + (MAXR + 1) * (KICK + SETTLE + CHECK) + 12;
      gen_random(len);
      run_scn(e0, -1, len);
      drop_en();
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
